// File: rtl/e_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, runs mult/div with fixed latency,
// and serves mthi/mtlo writes and mfhi/mflo reads.
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       MDUop,
    input  logic             valid,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MDUout,
    input  logic             rd_hi
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW_RAW     = $clog2(MAX_CYCLES + 1);
    localparam int CW         = (CW_RAW < 4) ? 4 : CW_RAW;

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state_r, state_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic                busy_r, busy_s;
    logic [WIDTH-1:0]    hi_r, hi_s, lo_r, lo_s;
    logic [WIDTH-1:0]    tmp_hi_r, tmp_hi_s, tmp_lo_r, tmp_lo_s;
    logic                skip_r, skip_s;

    logic [2*WIDTH-1:0]  a_sx_s, b_sx_s, a_zx_s, b_zx_s;
    logic [2*WIDTH-1:0]  prod_s_s, prod_u_s;
    logic                b_zero_s, div_ovf_s;
    logic [WIDTH-1:0]    b_safe_s;
    logic signed [WIDTH-1:0] a_sg_s, b_sg_s, q_sg_s, r_sg_s;
    logic [WIDTH-1:0]    q_u_s, r_u_s;

    // Operand extension and arithmetic datapath; a zero divisor is steered to 1 so the divider never sees it.
    always_comb begin
        a_sx_s    = {{WIDTH{A[WIDTH-1]}}, A};
        b_sx_s    = {{WIDTH{B[WIDTH-1]}}, B};
        a_zx_s    = {{WIDTH{1'b0}}, A};
        b_zx_s    = {{WIDTH{1'b0}}, B};
        prod_s_s  = a_sx_s * b_sx_s;
        prod_u_s  = a_zx_s * b_zx_s;
        b_zero_s  = (B == {WIDTH{1'b0}});
        div_ovf_s = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == {WIDTH{1'b1}});
        if (b_zero_s || div_ovf_s) begin
            b_safe_s = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            b_safe_s = B;
        end
        a_sg_s = A;
        b_sg_s = b_safe_s;
        q_sg_s = a_sg_s / b_sg_s;
        r_sg_s = a_sg_s % b_sg_s;
        q_u_s  = A / b_safe_s;
        r_u_s  = A % b_safe_s;
    end

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        busy_s   = busy_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        tmp_hi_s = tmp_hi_r;
        tmp_lo_s = tmp_lo_r;
        skip_s   = skip_r;
        case (state_r)
            IDLE: begin
                if (valid) begin
                    case (MDUop)
                        3'd1: begin
                            tmp_hi_s = prod_s_s[2*WIDTH-1:WIDTH];
                            tmp_lo_s = prod_s_s[WIDTH-1:0];
                            skip_s   = 1'b0;
                            cnt_s    = CW'(MULT_CYCLES);
                            busy_s   = 1'b1;
                            state_s  = BUSY;
                        end
                        3'd2: begin
                            tmp_hi_s = prod_u_s[2*WIDTH-1:WIDTH];
                            tmp_lo_s = prod_u_s[WIDTH-1:0];
                            skip_s   = 1'b0;
                            cnt_s    = CW'(MULT_CYCLES);
                            busy_s   = 1'b1;
                            state_s  = BUSY;
                        end
                        3'd3: begin
                            if (div_ovf_s) begin
                                tmp_hi_s = {WIDTH{1'b0}};
                                tmp_lo_s = A;
                            end else begin
                                tmp_hi_s = r_sg_s;
                                tmp_lo_s = q_sg_s;
                            end
                            skip_s  = b_zero_s;
                            cnt_s   = CW'(DIV_CYCLES);
                            busy_s  = 1'b1;
                            state_s = BUSY;
                        end
                        3'd4: begin
                            tmp_hi_s = r_u_s;
                            tmp_lo_s = q_u_s;
                            skip_s   = b_zero_s;
                            cnt_s    = CW'(DIV_CYCLES);
                            busy_s   = 1'b1;
                            state_s  = BUSY;
                        end
                        3'd5: hi_s = A;
                        3'd6: lo_s = A;
                        default: begin
                            state_s = IDLE;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                    // A divide by zero runs the full latency but leaves HI/LO untouched.
                    if (!skip_r) begin
                        hi_s = tmp_hi_r;
                        lo_s = tmp_lo_r;
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                end else begin
                    state_s = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, counter, staged result and architectural HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            tmp_hi_r <= {WIDTH{1'b0}};
            tmp_lo_r <= {WIDTH{1'b0}};
            skip_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            tmp_hi_r <= tmp_hi_s;
            tmp_lo_r <= tmp_lo_s;
            skip_r   <= skip_s;
        end
    end

    assign busy   = busy_r;
    assign HI     = hi_r;
    assign LO     = lo_r;
    assign MDUout = rd_hi ? hi_r : lo_r;

endmodule

// File: tb/tb_e_mdu.sv
// Randomised self-checking bench for e_mdu against an arithmetic reference model.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  MDUop;
    logic        valid;
    logic        busy;
    logic [31:0] HI, LO, MDUout;
    logic        rd_hi;

    int n_cmp;
    int n_err;
    logic [31:0] hi_m, lo_m;

    e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDUop(MDUop), .valid(valid),
        .busy(busy), .HI(HI), .LO(LO), .MDUout(MDUout), .rd_hi(rd_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: returns expected busy length and updates hi_m/lo_m.
    function automatic int model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic v);
        int          sa, sb, q, r;
        longint      ps;
        logic [63:0] p;
        if (!v) return 0;
        sa = a;
        sb = b;
        case (op)
            3'd1: begin
                ps = longint'(sa) * longint'(sb);
                p  = ps;
                hi_m = p[63:32]; lo_m = p[31:0];
                return 5;
            end
            3'd2: begin
                p = 64'(a) * 64'(b);
                hi_m = p[63:32]; lo_m = p[31:0];
                return 5;
            end
            3'd3: begin
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo_m = a; hi_m = 32'd0;
                end else begin
                    q = sa / sb; r = sa % sb;
                    lo_m = q; hi_m = r;
                end
                return 10;
            end
            3'd4: begin
                if (b != 32'd0) begin
                    lo_m = a / b; hi_m = a % b;
                end
                return 10;
            end
            3'd5: begin hi_m = a; return 0; end
            3'd6: begin lo_m = a; return 0; end
            default: return 0;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic v, input bit inject);
        int n, n_exp;
        @(negedge clk);
        A = a; B = b; MDUop = op; valid = v;
        n_exp = model(op, a, b, v);
        @(posedge clk); #1;
        valid = 1'b0; MDUop = 3'd0;
        n = 0;
        while (busy && n < 40) begin
            if (inject && n == 2) begin
                valid = 1'b1; MDUop = 3'd1; A = 32'd7; B = 32'd9;
            end else begin
                valid = 1'b0; MDUop = 3'd0;
            end
            @(posedge clk); #1;
            n++;
        end
        valid = 1'b0; MDUop = 3'd0;
        check("busy_cycles", 32'(n), 32'(n_exp));
        check("HI", HI, hi_m);
        check("LO", LO, lo_m);
    endtask

    task automatic check_read;
        rd_hi = 1'b1; #1;
        check("MDUout_hi", MDUout, hi_m);
        rd_hi = 1'b0; #1;
        check("MDUout_lo", MDUout, lo_m);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] ra, rb;
        logic        rv;
        n_cmp = 0; n_err = 0;
        hi_m = 32'd0; lo_m = 32'd0;
        A = 32'd0; B = 32'd0; MDUop = 3'd0; valid = 1'b0; rd_hi = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_HI", HI, 32'd0);
        check("rst_LO", LO, 32'd0);
        @(negedge clk); reset = 1'b0;

        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(3'd5, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
        run_op(3'd6, 32'h9ABC_DEF0, 32'h0, 1'b1, 1'b0);
        run_op(3'd4, 32'h0000_1234, 32'h0, 1'b1, 1'b0);
        check_read();
        run_op(3'd3, 32'h0000_0042, 32'h0, 1'b1, 1'b0);
        run_op(3'd4, 32'd1000, 32'd7, 1'b1, 1'b1);
        run_op(3'd7, 32'h1111_1111, 32'h2, 1'b1, 1'b0);
        run_op(3'd5, 32'h2222_2222, 32'h2, 1'b0, 1'b0);

        // Asynchronous reset in the second busy cycle of a mult.
        run_op(3'd6, 32'h5555_5555, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        A = 32'd3; B = 32'd4; MDUop = 3'd1; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; MDUop = 3'd0;
        @(posedge clk); #2;
        reset = 1'b1; #1;
        hi_m = 32'd0; lo_m = 32'd0;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_HI", HI, 32'd0);
        check("arst_LO", LO, 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("no_commit_busy", 32'(busy), 32'd0);
        check("no_commit_LO", LO, 32'd0);
        run_op(3'd1, 32'd3, 32'd4, 1'b1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            rv = ($urandom_range(0, 9) != 0);
            run_op(op, ra, rb, rv, ($urandom_range(0, 3) == 0));
            if (i % 10 == 0) check_read();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
